stack_arbiter: RTL and testbench

Shares one STACK frame engine (4-deep, 4-bit push/pop, 6-bit sum result) between two requesters. The arbiter grants whole frames round-robin and forwards the granted requester's push/pop stream to the stack through one register stage. It then waits for the stack's sum and returns it to that requester, tagged as valid or empty. The block sits between the requester logic and the single STACK instance in the lab datapath.

---
 rtl/stack_pkg.sv | 23 ++
 rtl/stack_arbiter_if.sv | 45 ++++
 rtl/rr_pick2.sv | 19 +
 rtl/stack_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_stack_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared types and sizing for the STACK frame arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stack_pkg;

  localparam int STACK_DEPTH = 4;
  localparam int DATA_W      = 4;
  localparam int SUM_W       = 6;

  // Largest sum a full stack can report; SUM_W must be able to hold it.
  localparam int MAX_SUM = STACK_DEPTH * ((1 << DATA_W) - 1);

  localparam int RESULT_WAIT_DEF = 3;
  localparam int GRANT_TO_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/stack_arbiter_if.sv
// Bundle of requester-side and stack-side signals around the arbiter.
// Latency: n/a (wires only).
// Backpressure: none; requesters hold req until granted, ops flow one per cycle.
// Ports: req/valid/op/in per requester, gnt per requester, s_* stream to the
// stack, s_out/s_out_valid back from it, res/res_valid*/res_empty results.
interface stack_arbiter_if;
  import stack_pkg::*;

  logic              req0;
  logic              req1;
  logic              valid0;
  logic              valid1;
  logic              op0;
  logic              op1;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic              gnt0;
  logic              gnt1;
  logic              s_in_valid;
  logic              s_op;
  logic [DATA_W-1:0] s_in;
  logic [SUM_W-1:0]  s_out;
  logic              s_out_valid;
  logic [SUM_W-1:0]  res;
  logic              res_valid0;
  logic              res_valid1;
  logic              res_empty;

  // Requester/stack environment side.
  modport master (
    output req0, req1, valid0, valid1, op0, op1, in0, in1,
    output s_out, s_out_valid,
    input  gnt0, gnt1, s_in_valid, s_op, s_in,
    input  res, res_valid0, res_valid1, res_empty
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, valid0, valid1, op0, op1, in0, in1,
    input  s_out, s_out_valid,
    output gnt0, gnt1, s_in_valid, s_op, s_in,
    output res, res_valid0, res_valid1, res_empty
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the requester that was not last wins.
// Latency: combinational.
// Backpressure: none.
// Ports: req0/req1 request levels, last = previous owner, any = some request,
// pick = index of the winner (0 when nobody requests).
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic any,
  output logic pick
);

  always_comb begin
    any  = req0 | req1;
    pick = (req0 && req1) ? ~last : req1;
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one STACK frame engine between two requesters, whole frames round-robin.
// Latency: grant 1 cycle after req; ops reach the stack 1 cycle after valid;
//   result pulses 2 cycles after frame end (1+RESULT_WAIT when the stack is empty).
// Backpressure: requesters hold req until gnt; a granted frame streams ops with no stalls.
// Ports: clk, rst_n (async active-low), bus (slave side of stack_arbiter_if).
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int RESULT_WAIT = RESULT_WAIT_DEF,
  parameter int GRANT_TO    = GRANT_TO_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  stack_arbiter_if.slave bus
);

  localparam int TO_W   = $clog2(GRANT_TO + 1);
  localparam int WAIT_W = $clog2(RESULT_WAIT + 1);

  arb_state_e        state, state_nxt;
  logic              owner, owner_nxt;
  logic              last, last_nxt;
  logic              seen, seen_nxt;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;

  logic              gnt0, gnt0_nxt;
  logic              gnt1, gnt1_nxt;
  logic              s_in_valid, s_in_valid_nxt;
  logic              s_op, s_op_nxt;
  logic [DATA_W-1:0] s_in, s_in_nxt;
  logic [SUM_W-1:0]  res, res_nxt;
  logic              res_valid0, res_valid0_nxt;
  logic              res_valid1, res_valid1_nxt;
  logic              res_empty, res_empty_nxt;

  logic              pick_any;
  logic              pick_idx;

  // Views of the current frame owner's inputs; the other requester is ignored.
  logic              own_req;
  logic              own_valid;
  logic              own_op;
  logic [DATA_W-1:0] own_in;

  rr_pick2 u_pick (
    .req0 (bus.req0),
    .req1 (bus.req1),
    .last (last),
    .any  (pick_any),
    .pick (pick_idx)
  );

  always_comb begin
    own_req   = owner ? bus.req1   : bus.req0;
    own_valid = owner ? bus.valid1 : bus.valid0;
    own_op    = owner ? bus.op1    : bus.op0;
    own_in    = owner ? bus.in1    : bus.in0;
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_nxt       = last;
    seen_nxt       = seen;
    to_cnt_nxt     = to_cnt;
    wait_cnt_nxt   = wait_cnt;
    gnt0_nxt       = gnt0;
    gnt1_nxt       = gnt1;
    s_in_valid_nxt = s_in_valid;
    s_op_nxt       = s_op;
    s_in_nxt       = s_in;
    res_nxt        = res;
    res_empty_nxt  = res_empty;
    res_valid0_nxt = 1'b0;
    res_valid1_nxt = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nxt  = ST_GRANT;
          owner_nxt  = pick_idx;
          gnt0_nxt   = ~pick_idx;
          gnt1_nxt   = pick_idx;
          seen_nxt   = 1'b0;
          to_cnt_nxt = '0;
        end
      end

      ST_GRANT: begin
        if (own_valid) begin
          s_in_valid_nxt = 1'b1;
          s_op_nxt       = own_op;
          s_in_nxt       = own_in;
          seen_nxt       = 1'b1;
        end else begin
          s_in_valid_nxt = 1'b0;
          if (seen) begin
            // Frame end: the stack reports its sum once it sees valid low.
            gnt0_nxt     = 1'b0;
            gnt1_nxt     = 1'b0;
            wait_cnt_nxt = '0;
            state_nxt    = ST_WAIT;
          end else if (!own_req || (to_cnt == TO_W'(GRANT_TO - 1))) begin
            // Abort before any op: no result, LAST stays as it was.
            gnt0_nxt  = 1'b0;
            gnt1_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end else begin
            to_cnt_nxt = to_cnt + 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (bus.s_out_valid) begin
          res_nxt        = bus.s_out;
          res_empty_nxt  = 1'b0;
          res_valid0_nxt = ~owner;
          res_valid1_nxt = owner;
          state_nxt      = ST_DONE;
        end else if (wait_cnt == WAIT_W'(RESULT_WAIT)) begin
          // An empty stack never pulses s_out_valid, so give up and report empty.
          res_nxt        = '0;
          res_empty_nxt  = 1'b1;
          res_valid0_nxt = ~owner;
          res_valid1_nxt = owner;
          state_nxt      = ST_DONE;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end

      ST_DONE: begin
        last_nxt  = owner;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last       <= 1'b1;   // requester 0 wins the first tie
      seen       <= 1'b0;
      to_cnt     <= '0;
      wait_cnt   <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      s_in_valid <= 1'b0;
      s_op       <= 1'b0;
      s_in       <= '0;
      res        <= '0;
      res_valid0 <= 1'b0;
      res_valid1 <= 1'b0;
      res_empty  <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last       <= last_nxt;
      seen       <= seen_nxt;
      to_cnt     <= to_cnt_nxt;
      wait_cnt   <= wait_cnt_nxt;
      gnt0       <= gnt0_nxt;
      gnt1       <= gnt1_nxt;
      s_in_valid <= s_in_valid_nxt;
      s_op       <= s_op_nxt;
      s_in       <= s_in_nxt;
      res        <= res_nxt;
      res_valid0 <= res_valid0_nxt;
      res_valid1 <= res_valid1_nxt;
      res_empty  <= res_empty_nxt;
    end
  end

  assign bus.gnt0       = gnt0;
  assign bus.gnt1       = gnt1;
  assign bus.s_in_valid = s_in_valid;
  assign bus.s_op       = s_op;
  assign bus.s_in       = s_in;
  assign bus.res        = res;
  assign bus.res_valid0 = res_valid0;
  assign bus.res_valid1 = res_valid1;
  assign bus.res_empty  = res_empty;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural 4-deep STACK attached.
// Latency: n/a.
// Backpressure: n/a.
module tb_stack_arbiter;
  import stack_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  stack_arbiter_if bus ();

  stack_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural STACK: push/pop on s_in_valid, sum reported one cycle after
  // s_in_valid falls, no report when empty. Contents survive arbiter reset.
  logic [DATA_W-1:0] stk [STACK_DEPTH];
  logic [2:0]        stk_cnt       = '0;
  logic              prev_vld      = 1'b0;
  logic              stk_out_valid = 1'b0;
  logic [SUM_W-1:0]  stk_out       = '0;

  assign bus.s_out_valid = stk_out_valid;
  assign bus.s_out       = stk_out;

  function automatic logic [SUM_W-1:0] stk_sum();
    logic [SUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (3'(i) < stk_cnt) s = s + SUM_W'(stk[i]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (bus.s_in_valid) begin
      if (bus.s_op) begin
        if (stk_cnt < 3'd4) begin
          stk[stk_cnt[1:0]] <= bus.s_in;
          stk_cnt           <= stk_cnt + 3'd1;
        end
      end else if (stk_cnt != 3'd0) begin
        stk_cnt <= stk_cnt - 3'd1;
      end
    end
    stk_out_valid <= prev_vld && !bus.s_in_valid && (stk_cnt != 3'd0);
    stk_out       <= stk_sum();
    prev_vld      <= bus.s_in_valid;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt0"},       32'(bus.gnt0), 0);
    chk({tag, " gnt1"},       32'(bus.gnt1), 0);
    chk({tag, " s_in_valid"}, 32'(bus.s_in_valid), 0);
    chk({tag, " s_op"},       32'(bus.s_op), 0);
    chk({tag, " s_in"},       32'(bus.s_in), 0);
    chk({tag, " res"},        32'(bus.res), 0);
    chk({tag, " res_valid0"}, 32'(bus.res_valid0), 0);
    chk({tag, " res_valid1"}, 32'(bus.res_valid1), 0);
    chk({tag, " res_empty"},  32'(bus.res_empty), 0);
  endtask

  // Waits (bounded) for any grant, then checks it went to exp.
  task automatic wait_gnt(input logic exp, input string tag);
    int n;
    n = 0;
    tick();
    while (!(bus.gnt0 || bus.gnt1) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " gnt0"}, 32'(bus.gnt0), 32'(!exp));
    chk({tag, " gnt1"}, 32'(bus.gnt1), 32'(exp));
  endtask

  task automatic send_op(input logic r, input logic op, input logic [3:0] d);
    if (r) begin
      bus.valid1 = 1'b1; bus.op1 = op; bus.in1 = d;
    end else begin
      bus.valid0 = 1'b1; bus.op0 = op; bus.in0 = d;
    end
    tick();
    chk("op s_in_valid", 32'(bus.s_in_valid), 1);
    chk("op s_op",       32'(bus.s_op), 32'(op));
    chk("op s_in",       32'(bus.s_in), 32'(d));
  endtask

  task automatic end_frame(input logic r);
    if (r) bus.valid1 = 1'b0;
    else   bus.valid0 = 1'b0;
    tick();
    chk("end gnt",        32'(r ? bus.gnt1 : bus.gnt0), 0);
    chk("end s_in_valid", 32'(bus.s_in_valid), 0);
  endtask

  // dly = cycles from frame end to the result pulse.
  task automatic expect_result(input logic r, input int dly, input logic empty,
                               input logic [5:0] val);
    for (int k = 1; k <= dly; k++) begin
      tick();
      chk(r ? "res_valid1" : "res_valid0",
          32'(r ? bus.res_valid1 : bus.res_valid0), 32'(k == dly));
      chk("other res_valid", 32'(r ? bus.res_valid0 : bus.res_valid1), 0);
      if (k == dly) begin
        chk("res",       32'(bus.res), 32'(val));
        chk("res_empty", 32'(bus.res_empty), 32'(empty));
      end
    end
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.valid0 = 1'b0; bus.valid1 = 1'b0;
    bus.op0 = 1'b0; bus.op1 = 1'b0;
    bus.in0 = '0; bus.in1 = '0;

    // Reset values.
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Requester 1 alone: push 2, pop on an empty stack -> empty result.
    bus.req1 = 1'b1;
    wait_gnt(1'b1, "r1 only");
    send_op(1'b1, 1'b1, 4'd2);
    send_op(1'b1, 1'b0, 4'd1);
    end_frame(1'b1);
    bus.req1 = 1'b0;
    expect_result(1'b1, 1 + RESULT_WAIT_DEF, 1'b1, 6'd0);
    tick();
    chk("empty pulse width", 32'(bus.res_valid1), 0);

    // Requester 0: push 3, 5, 7 -> sum 15.
    bus.req0 = 1'b1;
    wait_gnt(1'b0, "r0 only");
    send_op(1'b0, 1'b1, 4'd3);
    send_op(1'b0, 1'b1, 4'd5);
    send_op(1'b0, 1'b1, 4'd7);
    end_frame(1'b0);
    bus.req0 = 1'b0;
    expect_result(1'b0, 2, 1'b0, 6'd15);

    // VALID1 toggling under GNT0 must not reach the stack; pop 7 -> sum 8.
    bus.req0 = 1'b1;
    wait_gnt(1'b0, "isolate");
    bus.valid1 = 1'b1; bus.op1 = 1'b1; bus.in1 = 4'd15;
    tick();
    chk("foreign valid ignored", 32'(bus.s_in_valid), 0);
    bus.valid1 = 1'b0;
    send_op(1'b0, 1'b0, 4'd0);
    bus.valid1 = 1'b1;
    end_frame(1'b0);
    bus.valid1 = 1'b0;
    bus.req0 = 1'b0;
    expect_result(1'b0, 2, 1'b0, 6'd8);

    // Tie with LAST=0 goes to 1; no VALID1 for 8 cycles aborts the grant.
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_gnt(1'b1, "tie after r0");
    for (int k = 1; k <= GRANT_TO_DEF; k++) begin
      tick();
      chk("timeout gnt1", 32'(bus.gnt1), 32'(k < GRANT_TO_DEF));
    end
    bus.req1 = 1'b0;
    wait_gnt(1'b0, "after timeout");
    chk("timeout no result", 32'(bus.res_valid1), 0);
    send_op(1'b0, 1'b1, 4'd1);
    end_frame(1'b0);
    bus.req0 = 1'b0;
    expect_result(1'b0, 2, 1'b0, 6'd9);

    // Withdrawn request aborts; LAST stays 0 so the next tie still goes to 1.
    bus.req1 = 1'b1;
    wait_gnt(1'b1, "withdraw grant");
    bus.req1 = 1'b0;
    tick();
    chk("withdraw gnt1", 32'(bus.gnt1), 0);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_gnt(1'b1, "last unchanged");
    bus.req0 = 1'b0;
    send_op(1'b1, 1'b1, 4'd4);
    end_frame(1'b1);
    bus.req1 = 1'b0;
    expect_result(1'b1, 2, 1'b0, 6'd13);

    // Both held out of reset: frames alternate 0, 1, 0, 1.
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_gnt(1'b0, "alt 1");
    send_op(1'b0, 1'b0, 4'd0);
    end_frame(1'b0);
    expect_result(1'b0, 2, 1'b0, 6'd9);
    wait_gnt(1'b1, "alt 2");
    send_op(1'b1, 1'b0, 4'd0);
    end_frame(1'b1);
    expect_result(1'b1, 2, 1'b0, 6'd8);
    wait_gnt(1'b0, "alt 3");
    send_op(1'b0, 1'b1, 4'd6);
    end_frame(1'b0);
    expect_result(1'b0, 2, 1'b0, 6'd14);
    wait_gnt(1'b1, "alt 4");
    send_op(1'b1, 1'b0, 4'd0);
    end_frame(1'b1);
    expect_result(1'b1, 2, 1'b0, 6'd8);

    // Reset asserted mid-GRANT clears outputs at once; tie then goes to 0.
    wait_gnt(1'b0, "pre-reset");
    send_op(1'b0, 1'b1, 4'd9);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async reset");
    bus.valid0 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    wait_gnt(1'b0, "post-reset tie");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
